// File: rtl/fc_buff_pkg.sv
// Shared types and sizing for the FC data buffer read sequencer.
//   SRAM_DEPTH  buffer depth in words
//   DATA_WIDTH  buffer word width
//   REP_WIDTH   width of the repeat-count field
//   AW / LW     address width / length width (length can equal SRAM_DEPTH)
package fc_buff_pkg;

    localparam int unsigned SRAM_DEPTH = 1024;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned REP_WIDTH  = 8;
    localparam int unsigned AW         = $clog2(SRAM_DEPTH);
    localparam int unsigned LW         = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    // One buffered stream beat: word plus pass/command end markers.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  vlast;
        logic                  last;
    } fifo_entry_t;

endpackage

// File: rtl/fc_stream_fifo2.sv
// Two-entry FIFO holding stream beats between the SRAM read port and the
// output handshake.
//   clk, rst  clock, async active-high reset (empties the FIFO)
//   push, din write one entry (caller guarantees occ < 2 or a same-cycle pop)
//   pop       retire the head entry (caller guarantees occ > 0)
//   occ       current occupancy 0..2
//   head      oldest entry, all-zero after reset
module fc_stream_fifo2
    import fc_buff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output logic [1:0]  occ,
    output fifo_entry_t head
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // Storage, pointers and occupancy; push+pop in one cycle leaves occ unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fc_buff_reader.sv
// Read-side sequencer for the FC data buffer SRAM. On start it reads LEN words
// from BASE (wrapping at the buffer end), repeats the vector max(REPEAT,1)
// times, and streams the words over valid/ready with per-pass and final markers.
//   clk, rst               clock, async active-high reset (aborts, no done)
//   start, base_addr, len, repeat_cnt   command, sampled only when idle
//   busy, done             command in progress / 1-cycle completion pulse
//   enb, addrb, dob        buffer read port (dob valid 1 cycle after enb)
//   m_data, m_valid, m_ready, m_vlast, m_last   output stream
module fc_buff_reader
    import fc_buff_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [LW-1:0]         len,
    input  logic [REP_WIDTH-1:0]  repeat_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [AW-1:0]         addrb,
    input  logic [DATA_WIDTH-1:0] dob,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_vlast,
    output logic                  m_last
);

    state_t               state;
    logic [AW-1:0]        base_r;
    logic [LW-1:0]        len_r;
    logic [REP_WIDTH-1:0] rep_last_r;
    logic [AW-1:0]        idx;
    logic [REP_WIDTH-1:0] pass;
    logic                 inflight;
    logic                 vlast_q;
    logic                 last_q;

    logic                 issue_vlast;
    logic                 issue_last;
    logic                 pop;
    logic [1:0]           occ;
    logic [2:0]           credit;
    fifo_entry_t          push_entry;
    fifo_entry_t          head;

    assign issue_vlast = (LW'(idx) == (len_r - LW'(1)));
    assign issue_last  = issue_vlast && (pass == rep_last_r);
    assign addrb       = base_r + idx;
    assign pop         = m_valid && m_ready;

    // Slots already spoken for after this cycle's pop: buffered + in flight.
    // enb depends on m_ready in the same cycle so a stream with m_ready held
    // high gets one word per cycle.
    assign credit = 3'(occ) + 3'(inflight) - 3'(pop);

    always_comb begin
        enb = 1'b0;
        if ((state == ISSUE) && (credit < 3'd2)) begin
            enb = 1'b1;
        end
    end

    // Sequencer: command latch, address/pass counters, done/busy, read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            base_r     <= '0;
            len_r      <= '0;
            rep_last_r <= '0;
            idx        <= '0;
            pass       <= '0;
            inflight   <= 1'b0;
            vlast_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= enb;
            // Markers travel alongside the read so they meet dob next cycle.
            if (enb) begin
                vlast_q <= issue_vlast;
                last_q  <= issue_last;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r     <= base_addr;
                        len_r      <= len;
                        rep_last_r <= (repeat_cnt == '0) ? '0
                                                          : repeat_cnt - REP_WIDTH'(1);
                        idx        <= '0;
                        pass       <= '0;
                        busy       <= 1'b1;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (enb) begin
                        if (issue_vlast) begin
                            idx <= '0;
                            if (issue_last) begin
                                state <= DRAIN;
                            end else begin
                                pass <= pass + REP_WIDTH'(1);
                            end
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Empty FIFO with nothing in flight means the last beat
                    // has already been accepted.
                    if ((occ == 2'd0) && !inflight) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign push_entry = '{data: dob, vlast: vlast_q, last: last_q};

    fc_stream_fifo2 u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (push_entry),
        .pop  (pop),
        .occ  (occ),
        .head (head)
    );

    assign m_valid = (occ != 2'd0);
    assign m_data  = head.data;
    assign m_vlast = head.vlast;
    assign m_last  = head.last;

endmodule

// File: tb/tb_fc_buff_reader.sv
// Randomized self-checking bench for fc_buff_reader against a queue-based
// model of the expected address and beat sequences.
module tb_fc_buff_reader;
    import fc_buff_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [LW-1:0]         len;
    logic [REP_WIDTH-1:0]  repeat_cnt;
    logic                  busy;
    logic                  done;
    logic                  enb;
    logic [AW-1:0]         addrb;
    logic [DATA_WIDTH-1:0] dob = '0;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_vlast;
    logic                  m_last;

    fc_buff_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .repeat_cnt (repeat_cnt),
        .busy       (busy),
        .done       (done),
        .enb        (enb),
        .addrb      (addrb),
        .dob        (dob),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_vlast    (m_vlast),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];
    always @(posedge clk) if (enb) dob <= mem[addrb];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Model state: expected addresses and beats {data, vlast, last}.
    int                        exp_addr [$];
    logic [DATA_WIDTH+1:0]     exp_beat [$];
    int cyc = 0;
    int start_cyc, first_enb_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
    int beat_cnt, done_cnt, exp_total;
    int ready_mode = 0;
    int stall_left = 0;
    bit prev_stall = 1'b0;
    logic [DATA_WIDTH+1:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic build_expect(input int b, input int l, input int r);
        int passes;
        passes = (r == 0) ? 1 : r;
        exp_total = passes * l;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < l; i++) begin
                int a;
                bit vl, la;
                a  = (b + i) % SRAM_DEPTH;
                vl = (i == l - 1);
                la = vl && (p == passes - 1);
                exp_addr.push_back(a);
                exp_beat.push_back({mem[a], vl, la});
            end
        end
    endtask

    // Stream sink: either always ready, or random with occasional 5-cycle stalls.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                m_ready = 1'b1;
            end else if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                m_ready    = 1'b0;
                stall_left = 4;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: read addresses, beat order/content, stall stability, done pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (enb) begin
                if (first_enb_cyc < 0) first_enb_cyc = cyc;
                if (exp_addr.size() == 0) check("enb_unexpected", 32'd1, 32'd0);
                else check("addrb", 32'(addrb), 32'(exp_addr.pop_front()));
            end
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'({m_data, m_vlast, m_last}), 32'(prev_word));
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_beat.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
                else check("beat", 32'({m_data, m_vlast, m_last}), 32'(exp_beat.pop_front()));
                beat_cnt++;
                last_beat_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_data, m_vlast, m_last};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        beat_cnt        = 0;
        done_cnt        = 0;
        first_enb_cyc   = -1;
        first_valid_cyc = -1;
        last_beat_cyc   = -1;
        done_cyc        = -1;
    endtask

    task automatic issue_start(input int b, input int l, input int r);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = AW'(b);
        len        = LW'(l);
        repeat_cnt = REP_WIDTH'(r);
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_cmd(input int b, input int l, input int r, input int rmode,
                           input bit extra_start);
        clear_stats();
        build_expect(b, l, r);
        ready_mode = rmode;
        issue_start(b, l, r);
        if (extra_start) begin
            repeat (5) @(posedge clk);
            #1;
            start     = 1'b1;
            base_addr = AW'($urandom_range(0, SRAM_DEPTH - 1));
            len       = LW'(5);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int t = 0; t < 8000 && done_cnt == 0; t++) @(negedge clk);
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("done_once", 32'(done_cnt), 32'd1);
        check("beat_count", 32'(beat_cnt), 32'(exp_total));
        check("beats_left", 32'(exp_beat.size()), 32'd0);
        check("addrs_left", 32'(exp_addr.size()), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  32'(busy),    32'd0);
        check({tag, "_done"},  32'(done),    32'd0);
        check({tag, "_enb"},   32'(enb),     32'd0);
        check({tag, "_addrb"}, 32'(addrb),   32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_data"},  32'(m_data),  32'd0);
        check({tag, "_vlast"}, 32'(m_vlast), 32'd0);
        check({tag, "_last"},  32'(m_last),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = DATA_WIDTH'(i);
        clear_stats();
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        len        = '0;
        repeat_cnt = '0;
        #23;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic vector: latency and full throughput with m_ready held high.
        run_cmd(10, 4, 1, 0, 1'b0);
        check("lat_enb",   32'(first_enb_cyc - start_cyc),       32'd1);
        check("lat_valid", 32'(first_valid_cyc - start_cyc),     32'd3);
        check("throughput", 32'(last_beat_cyc - first_valid_cyc), 32'd3);

        // Address wrap at the end of the buffer.
        run_cmd(1022, 4, 1, 0, 1'b0);
        // Two passes, then repeat 0 treated as one pass.
        run_cmd(0, 3, 2, 0, 1'b0);
        run_cmd(50, 3, 0, 0, 1'b0);
        // Random backpressure with stalls.
        run_cmd(200, 8, 1, 1, 1'b0);

        // Empty command: immediate done, no reads, no beats.
        run_cmd(5, 0, 1, 0, 1'b0);
        check("len0_no_enb",   32'(first_enb_cyc),   32'hFFFF_FFFF);
        check("len0_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
        check("len0_done_lat", 32'((done_cyc - start_cyc) inside {[1:3]}), 32'd1);

        // Start while busy is ignored.
        run_cmd(300, 40, 1, 0, 1'b1);

        // Whole-buffer vector.
        run_cmd(700, SRAM_DEPTH, 1, 0, 1'b0);

        // Abort by reset mid-vector.
        clear_stats();
        build_expect(400, 8, 1);
        ready_mode = 0;
        issue_start(400, 8, 1);
        for (int t = 0; t < 100 && beat_cnt < 3; t++) @(negedge clk);
        check("abort_reached", 32'(beat_cnt >= 3), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_addr.delete();
        exp_beat.delete();
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_cmd(400, 8, 1, 0, 1'b0);

        // Randomized commands over random buffer contents.
        for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = DATA_WIDTH'($urandom);
        for (int n = 0; n < 10; n++) begin
            run_cmd(int'($urandom_range(0, SRAM_DEPTH - 1)), int'($urandom_range(1, 24)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
